// File: rtl/lsu_bus_master.sv
// LSU-to-peripheral-bus initiator: one request at a time, sub-word stores via
// read-modify-write, load lane extraction/extension, misalignment and timeout errors.
module lsu_bus_master #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_en,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both 1; valid and its payload stay stable until that edge.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_WR      = 3'd2,
        S_RMW_RD  = 3'd3,
        S_RMW_GAP = 3'd4,
        S_RMW_WR  = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t           r_state;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_err;
    logic             r_bus_en;
    logic             r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_lane;
    logic [1:0]       r_size;
    logic             r_unsigned;
    logic [15:0]      r_wdata_lo;

    logic             w_misaligned;
    logic             w_timeout;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;
    logic [31:0]      w_merged;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign bus_en    = r_bus_en;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign dbg_state = r_state;

    assign w_misaligned = (req_size == 2'd3) ||
                          (req_size == 2'd1 && req_addr[0]) ||
                          (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_byte = bus_rdata[7:0];
        case (r_lane)
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            2'd3:    w_byte = bus_rdata[31:24];
            default: w_byte = bus_rdata[7:0];
        endcase
        w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_size)
            2'd0:    w_load_data = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_load_data = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = bus_rdata;
        endcase
    end

    // The bus has no byte strobes, so untouched lanes come from the word just read.
    always_comb begin
        w_merged = bus_rdata;
        if (r_size == 2'd0) begin
            case (r_lane)
                2'd1:    w_merged[15:8]  = r_wdata_lo[7:0];
                2'd2:    w_merged[23:16] = r_wdata_lo[7:0];
                2'd3:    w_merged[31:24] = r_wdata_lo[7:0];
                default: w_merged[7:0]   = r_wdata_lo[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata_lo;
        end else begin
            w_merged[15:0] = r_wdata_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_bus_en    <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_cnt       <= '0;
            r_lane      <= 2'd0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_wdata_lo  <= 16'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_lane      <= req_addr[1:0];
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_wdata_lo  <= req_wdata[15:0];
                        r_cnt       <= '0;
                        if (w_misaligned) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                            r_state     <= S_RESP;
                        end else begin
                            r_bus_en    <= 1'b1;
                            r_bus_addr  <= {req_addr[31:2], 2'b00};
                            r_bus_we    <= req_we && (req_size == 2'd2);
                            r_bus_wdata <= (req_we && req_size == 2'd2) ? req_wdata : 32'h0;
                            if (!req_we)
                                r_state <= S_RD;
                            else if (req_size == 2'd2)
                                r_state <= S_WR;
                            else
                                r_state <= S_RMW_RD;
                        end
                    end
                end
                S_RD, S_WR, S_RMW_RD, S_RMW_WR: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (bus_ready) begin
                        r_bus_en <= 1'b0;
                        r_bus_we <= 1'b0;
                        if (r_state == S_RMW_RD) begin
                            r_bus_we    <= 1'b1;
                            r_bus_wdata <= w_merged;
                            r_state     <= S_RMW_GAP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= (r_state == S_RD) ? w_load_data : 32'h0;
                            r_state     <= S_RESP;
                        end
                    end else if (w_timeout) begin
                        r_bus_en    <= 1'b0;
                        r_bus_we    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RMW_GAP: begin
                    r_bus_en <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= S_RMW_WR;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
